// File: rtl/decode_scoreboard.sv
// Decode-stage issue scoreboard: per-register pending-write counters gate issue on RAW hazards and counter room.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a source whose last pending write retires this cycle count as ready.
module decode_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic [4:0]          addr_rs1_i,
  input  logic [4:0]          addr_rs2_i,
  input  logic [4:0]          addr_rd_i,
  input  logic                uses_rs1_i,
  input  logic                uses_rs2_i,
  input  logic                rd_we_i,
  input  logic                ex_ready_i,
  output logic                issue_o,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_addr_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                err_o
);

  localparam int AW = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q;
  logic             err_d;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wb_hit;
  logic             rs1_clear;
  logic             rs2_clear;
  logic             rs1_pend;
  logic             rs2_pend;
  logic             hazard;
  logic             full;
  logic             rd_inc;

  assign rs1_cnt = cnt_q[addr_rs1_i];
  assign rs2_cnt = cnt_q[addr_rs2_i];
  assign rd_cnt  = cnt_q[addr_rd_i];

  // A writeback is only meaningful for a real register and when no flush wipes the table.
  assign wb_hit = wb_valid_i & (wb_addr_i != '0) & ~flush_i;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last outstanding write retiring now: execute forwards the value, so no stall.
  assign rs1_clear = wb_hit & (wb_addr_i == addr_rs1_i) & (rs1_cnt == CNT_ONE);
  assign rs2_clear = wb_hit & (wb_addr_i == addr_rs2_i) & (rs2_cnt == CNT_ONE);
`else
  assign rs1_clear = 1'b0;
  assign rs2_clear = 1'b0;
`endif

  assign rs1_pend = uses_rs1_i & (addr_rs1_i != '0) & (rs1_cnt != '0) & ~rs1_clear;
  assign rs2_pend = uses_rs2_i & (addr_rs2_i != '0) & (rs2_cnt != '0) & ~rs2_clear;
  assign hazard   = rs1_pend | rs2_pend;
  assign full     = rd_we_i & (addr_rd_i != '0) & (rd_cnt == CNT_MAX);

  assign dec_ready_o = ex_ready_i & ~hazard & ~full & ~flush_i;
  assign issue_o     = dec_valid_i & dec_ready_o;
  assign rd_inc      = issue_o & rd_we_i & (addr_rd_i != '0);

  always_comb begin
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else begin
        // Simultaneous issue and retire on the same register cancel out.
        if (rd_inc && (addr_rd_i == AW'(i)) && !(wb_hit && (wb_addr_i == AW'(i)))) begin
          if (cnt_q[i] == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else if (wb_hit && (wb_addr_i == AW'(i)) && !(rd_inc && (addr_rd_i == AW'(i)))) begin
          if (cnt_q[i] == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign busy_o[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_o[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  assign err_o = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard with a per-cycle reference model of the counter table.
module tb_decode_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        dec_valid_i, dec_ready_o;
  logic [4:0]  addr_rs1_i, addr_rs2_i, addr_rd_i;
  logic        uses_rs1_i, uses_rs2_i, rd_we_i;
  logic        ex_ready_i, issue_o;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic        flush_i;
  logic [31:0] busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  int m_cnt [32];
  bit m_err;

  decode_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .addr_rs1_i(addr_rs1_i), .addr_rs2_i(addr_rs2_i), .addr_rd_i(addr_rd_i),
    .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i), .rd_we_i(rd_we_i),
    .ex_ready_i(ex_ready_i), .issue_o(issue_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A source is pending if its register has outstanding writes, minus the bypass case.
  function automatic bit src_pending(input bit used, input int r);
    bit p;
    p = used && (r != 0) && (m_cnt[r] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (p && m_cnt[r] == 1 && wb_valid_i && int'(wb_addr_i) == r && !flush_i) p = 0;
`endif
    return p;
  endfunction

  function automatic bit exp_ready();
    bit full;
    full = rd_we_i && (addr_rd_i != 0) && (m_cnt[addr_rd_i] == 3);
    return ex_ready_i && !flush_i && !full &&
           !src_pending(uses_rs1_i, int'(addr_rs1_i)) &&
           !src_pending(uses_rs2_i, int'(addr_rs2_i));
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
    end else if (flush_i) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      bit inc, dec;
      int rd, wa;
      rd  = int'(addr_rd_i);
      wa  = int'(wb_addr_i);
      inc = dec_valid_i && exp_ready() && rd_we_i && rd != 0;
      dec = wb_valid_i && wa != 0;
      if (inc && dec && rd == wa) begin
        // net zero
      end else begin
        if (inc) begin
          if (m_cnt[rd] == 3) m_err = 1; else m_cnt[rd] = m_cnt[rd] + 1;
        end
        if (dec) begin
          if (m_cnt[wa] == 0) m_err = 1; else m_cnt[wa] = m_cnt[wa] - 1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      bit r;
      r = exp_ready();
      chk("cyc_ready", {31'b0, dec_ready_o}, {31'b0, r});
      chk("cyc_issue", {31'b0, issue_o}, {31'b0, r & dec_valid_i});
      chk("cyc_busy", busy_o, exp_busy());
      chk("cyc_err", {31'b0, err_o}, {31'b0, m_err});
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic we);
    dec_valid_i = 1'b1;
    addr_rs1_i = rs1; addr_rs2_i = rs2; addr_rd_i = rd;
    uses_rs1_i = u1; uses_rs2_i = u2; rd_we_i = we;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    wb_valid_i = v;
    wb_addr_i  = a;
  endtask

  initial begin
    rst_i = 1'b1;
    dec_valid_i = 0; addr_rs1_i = 0; addr_rs2_i = 0; addr_rd_i = 0;
    uses_rs1_i = 0; uses_rs2_i = 0; rd_we_i = 0; ex_ready_i = 1;
    wb_valid_i = 0; wb_addr_i = 0; flush_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk_en = 1;
    chk("reset_busy", busy_o, 32'h0);
    chk("reset_err", {31'b0, err_o}, 32'h0);

    // basic issue, zero latency
    instr(5, 6, 7, 1, 1, 1);
    #1 chk("t1_issue", {31'b0, issue_o}, 32'h1);
    step(); dec_valid_i = 0;
    #1 chk("t1_busy7", {31'b0, busy_o[7]}, 32'h1);

    // RAW on x7
    instr(7, 0, 10, 1, 0, 1);
    #1 chk("t2_stall", {31'b0, dec_ready_o}, 32'h0);
    step();
    chk("t2_stall2", {31'b0, dec_ready_o}, 32'h0);
    wb(1, 7);
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t2_bypass_issue", {31'b0, issue_o}, 32'h1);
    step(); wb(0, 0); dec_valid_i = 0;
`else
    chk("t2_wb_stall", {31'b0, issue_o}, 32'h0);
    step(); wb(0, 0);
    #1 chk("t2_issue_after_wb", {31'b0, issue_o}, 32'h1);
    step(); dec_valid_i = 0;
`endif
    #1 chk("t2_busy", busy_o, 32'h0000_0400);
    wb(1, 10); step(); wb(0, 0);

    // counter saturation on x3
    instr(0, 0, 3, 0, 0, 1);
    repeat (3) begin
      #1 chk("t3_issue", {31'b0, issue_o}, 32'h1);
      step();
    end
    #1 chk("t3_full", {31'b0, dec_ready_o}, 32'h0);
    step();
    wb(1, 3);
    #1 chk("t3_full_wb", {31'b0, issue_o}, 32'h0);
    step(); wb(0, 0);
    #1 chk("t3_issue4", {31'b0, issue_o}, 32'h1);
    step(); dec_valid_i = 0;
    wb(1, 3); repeat (3) step(); wb(0, 0);
    #1 chk("t3_drained", busy_o, 32'h0);
    chk("t3_err", {31'b0, err_o}, 32'h0);

    // x0 is invisible
    instr(0, 0, 0, 1, 1, 1);
    repeat (4) begin
      #1 chk("t4_x0_issue", {31'b0, issue_o}, 32'h1);
      step();
    end
    dec_valid_i = 0;
    wb(1, 0); step(); wb(0, 0);
    #1 chk("t4_busy", busy_o, 32'h0);
    chk("t4_err", {31'b0, err_o}, 32'h0);

    // flush
    instr(0, 0, 4, 0, 0, 1); step();
    instr(0, 0, 9, 0, 0, 1); step(); dec_valid_i = 0;
    #1 chk("t5_busy", busy_o, 32'h0000_0210);
    instr(0, 0, 11, 0, 0, 1); flush_i = 1;
    #1 chk("t5_flush_issue", {31'b0, issue_o}, 32'h0);
    step(); flush_i = 0; dec_valid_i = 0;
    #1 chk("t5_busy_clr", busy_o, 32'h0);
    wb(1, 4); step(); wb(0, 0);
    #1 chk("t5_err", {31'b0, err_o}, 32'h1);
    step();
    chk("t5_err_sticky", {31'b0, err_o}, 32'h1);

    // same-cycle issue and retire on x8
    instr(0, 0, 8, 0, 0, 1); step();
    instr(0, 0, 8, 0, 0, 1); wb(1, 8); step();
    dec_valid_i = 0; wb(0, 0);
    #1 chk("t6_busy8", {31'b0, busy_o[8]}, 32'h1);
    wb(1, 8); step(); wb(0, 0);
    #1 chk("t6_cnt8_was1", {31'b0, busy_o[8]}, 32'h0);

    // asynchronous reset mid-cycle
    instr(0, 0, 12, 0, 0, 1); step(); dec_valid_i = 0;
    #1 chk("t7_pre_busy", {31'b0, busy_o[12]}, 32'h1);
    #1 rst_i = 1'b1;
    #1 chk("t7_rst_busy", busy_o, 32'h0);
    chk("t7_rst_err", {31'b0, err_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (2) step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
